// File: rtl/flash_boot_loader_pkg.sv
// Shared state encoding, default parameters and flash address helper for the
// flash-to-SRAM boot loader.
package flash_boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ_LO  = 3'd1,
    ST_WAIT_LO = 3'd2,
    ST_REQ_HI  = 3'd3,
    ST_WAIT_HI = 3'd4,
    ST_WRITE   = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERR     = 3'd7
  } state_t;

  localparam logic [21:0] DEF_FLASH_BASE   = 22'h000000;
  localparam logic [19:0] DEF_RAM_BASE     = 20'h00000;
  localparam logic [19:0] DEF_WORD_COUNT   = 20'd1024;
  localparam int          DEF_WRITE_CYCLES = 2;
  localparam logic [15:0] DEF_TIMEOUT      = 16'd4096;

  // Low half-word address of word n; wraps silently modulo 2^22.
  function automatic logic [21:0] lo_half_addr(input logic [21:0] base, input logic [19:0] n);
    return base + {1'b0, n, 1'b0};
  endfunction

endpackage

// File: rtl/flash_boot_loader_sync_edge.sv
// Two-flop synchroniser with a rising-edge pulse, for asynchronous status
// levels such as flash ready or UART flags.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronise the level, then keep its previous value for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/flash_boot_loader.sv
// Copies WORD_COUNT 32-bit words from NOR flash (two half-word reads each)
// into SRAM, holding the core busy until done or timed out.
module flash_boot_loader
  import flash_boot_loader_pkg::*;
#(
  parameter logic [21:0] FLASH_BASE   = DEF_FLASH_BASE,
  parameter logic [19:0] RAM_BASE     = DEF_RAM_BASE,
  parameter logic [19:0] WORD_COUNT   = DEF_WORD_COUNT,
  parameter int          WRITE_CYCLES = DEF_WRITE_CYCLES,
  parameter logic [15:0] TIMEOUT      = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [21:0] flash_addr,
  input  logic [15:0] flash_data,
  input  logic        flash_data_ready,
  output logic [19:0] ram_addr,
  output logic [31:0] ram_data,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [3:0]  ram_sel,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [19:0] words_copied
);

  localparam logic [15:0] WC_LAST  = 16'(WRITE_CYCLES - 1);
  localparam logic [15:0] TMO_LAST = TIMEOUT - 16'd1;

  state_t      r_state;
  logic [15:0] r_tmo;
  logic [15:0] r_wcnt;
  logic        w_rise;
  logic [19:0] w_n_next;

  sync_edge u_ready_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (flash_data_ready),
    .o_rise  (w_rise)
  );

  assign w_n_next = words_copied + 20'd1;

  // Copy sequencer; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_tmo        <= 16'd0;
      r_wcnt       <= 16'd0;
      flash_addr   <= 22'd0;
      ram_addr     <= 20'd0;
      ram_data     <= 32'd0;
      ram_ce       <= 1'b0;
      ram_we       <= 1'b0;
      ram_sel      <= 4'h0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_copied <= 20'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            words_copied <= 20'd0;
            error        <= 1'b0;
            if (WORD_COUNT == 20'd0) begin
              r_state <= ST_DONE;
              done    <= 1'b1;
            end else begin
              r_state    <= ST_REQ_LO;
              done       <= 1'b0;
              busy       <= 1'b1;
              flash_addr <= FLASH_BASE;
              ram_addr   <= RAM_BASE;
            end
          end
        end
        ST_REQ_LO: begin
          r_tmo   <= 16'd0;
          r_state <= ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          if (w_rise) begin
            ram_data[15:0] <= flash_data;
            flash_addr     <= flash_addr + 22'd1;
            r_state        <= ST_REQ_HI;
          end else if (r_tmo == TMO_LAST) begin
            r_state <= ST_ERR;
            error   <= 1'b1;
            busy    <= 1'b0;
          end else begin
            r_tmo <= r_tmo + 16'd1;
          end
        end
        ST_REQ_HI: begin
          r_tmo   <= 16'd0;
          r_state <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (w_rise) begin
            ram_data[31:16] <= flash_data;
            ram_ce          <= 1'b1;
            ram_we          <= 1'b1;
            ram_sel         <= 4'hF;
            r_wcnt          <= 16'd0;
            r_state         <= ST_WRITE;
          end else if (r_tmo == TMO_LAST) begin
            r_state <= ST_ERR;
            error   <= 1'b1;
            busy    <= 1'b0;
          end else begin
            r_tmo <= r_tmo + 16'd1;
          end
        end
        ST_WRITE: begin
          if (r_wcnt == WC_LAST) begin
            ram_ce       <= 1'b0;
            ram_we       <= 1'b0;
            ram_sel      <= 4'h0;
            words_copied <= w_n_next;
            if (w_n_next == WORD_COUNT) begin
              r_state <= ST_DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              r_state    <= ST_REQ_LO;
              flash_addr <= lo_half_addr(FLASH_BASE, w_n_next);
              ram_addr   <= RAM_BASE + w_n_next;
            end
          end else begin
            r_wcnt <= r_wcnt + 16'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_boot_loader.sv
// Self-checking bench: randomised flash image and latencies, SRAM write
// scoreboard, plus timeout and zero-length instances.
module tb_flash_boot_loader;

  localparam logic [21:0] A_FB = 22'h000100;
  localparam logic [19:0] A_RB = 20'h00040;
  localparam int          A_WC = 4;
  localparam int          A_WRC = 2;

  logic clk;
  logic rst;

  logic        a_start, a_ready;
  logic [15:0] a_fdata;
  logic [21:0] a_flash_addr;
  logic [19:0] a_ram_addr, a_words;
  logic [31:0] a_ram_data;
  logic        a_ce, a_we, a_busy, a_done, a_error;
  logic [3:0]  a_sel;

  logic        t_start, t_ready;
  logic [15:0] t_fdata;
  logic [21:0] t_flash_addr;
  logic [19:0] t_ram_addr, t_words;
  logic [31:0] t_ram_data;
  logic        t_ce, t_we, t_busy, t_done, t_error;
  logic [3:0]  t_sel;

  logic        z_start, z_ready;
  logic [15:0] z_fdata;
  logic [21:0] z_flash_addr;
  logic [19:0] z_ram_addr, z_words;
  logic [31:0] z_ram_data;
  logic        z_ce, z_we, z_busy, z_done, z_error;
  logic [3:0]  z_sel;

  int n_checks = 0;
  int n_errors = 0;
  int a_we_cnt = 0, t_we_cnt = 0, z_we_cnt = 0, a_viol = 0;
  logic stale_mode = 1'b0;
  logic [7:0] key_hi, key_lo;
  logic [31:0] sram [logic [19:0]];

  flash_boot_loader #(.FLASH_BASE(A_FB), .RAM_BASE(A_RB), .WORD_COUNT(20'd4),
                      .WRITE_CYCLES(A_WRC), .TIMEOUT(16'd64)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .flash_addr(a_flash_addr),
    .flash_data(a_fdata), .flash_data_ready(a_ready), .ram_addr(a_ram_addr),
    .ram_data(a_ram_data), .ram_ce(a_ce), .ram_we(a_we), .ram_sel(a_sel),
    .busy(a_busy), .done(a_done), .error(a_error), .words_copied(a_words));

  flash_boot_loader #(.WORD_COUNT(20'd2), .TIMEOUT(16'd16)) dut_t (
    .clk(clk), .rst(rst), .start(t_start), .flash_addr(t_flash_addr),
    .flash_data(t_fdata), .flash_data_ready(t_ready), .ram_addr(t_ram_addr),
    .ram_data(t_ram_data), .ram_ce(t_ce), .ram_we(t_we), .ram_sel(t_sel),
    .busy(t_busy), .done(t_done), .error(t_error), .words_copied(t_words));

  flash_boot_loader #(.WORD_COUNT(20'd0)) dut_z (
    .clk(clk), .rst(rst), .start(z_start), .flash_addr(z_flash_addr),
    .flash_data(z_fdata), .flash_data_ready(z_ready), .ram_addr(z_ram_addr),
    .ram_data(z_ram_data), .ram_ce(z_ce), .ram_we(z_we), .ram_sel(z_sel),
    .busy(z_busy), .done(z_done), .error(z_error), .words_copied(z_words));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flash image contents: distinct low byte per address, random per run.
  function automatic logic [15:0] img(input logic [21:0] a);
    return {a[7:0] ^ key_hi, a[7:0] + key_lo};
  endfunction

  // Expected SRAM word n: two consecutive half-words, little-endian.
  function automatic logic [31:0] exp_word(input int n);
    logic [21:0] lo;
    lo = A_FB + 22'(2 * n);
    return {img(lo + 22'd1), img(lo)};
  endfunction

  function automatic logic [31:0] sram_get(input logic [19:0] k);
    return sram.exists(k) ? sram[k] : 32'hDEAD_DEAD;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_a_start();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
  endtask

  task automatic wait_a_done(input string tag);
    int w;
    w = 0;
    while (!a_done && w < 3000) begin
      step();
      w++;
    end
    chk({tag, "_done"}, {31'd0, a_done}, 32'd1);
  endtask

  task automatic check_image(input string tag);
    for (int n = 0; n < A_WC; n++)
      chk($sformatf("%s_word%0d", tag, n), sram_get(A_RB + 20'(n)), exp_word(n));
    chk({tag, "_words"}, {12'd0, a_words}, 32'd4);
    chk({tag, "_err_busy"}, {30'd0, a_error, a_busy}, 32'd0);
    chk({tag, "_we_cycles"}, a_we_cnt, 32'(A_WC * A_WRC));
  endtask

  // Flash model: ready drops on an address change (or lingers when stale_mode), then rises with data.
  initial begin
    logic [21:0] m_addr;
    int m_hold, m_low;
    a_ready = 1'b0;
    a_fdata = 16'h0000;
    m_addr = 22'h3FFFFF;
    m_hold = 0;
    m_low = 0;
    forever begin
      @(negedge clk);
      if (a_flash_addr !== m_addr) begin
        m_addr = a_flash_addr;
        if (stale_mode && a_ready) begin
          m_hold = 5;
          m_low = 3;
        end else begin
          a_ready = 1'b0;
          m_hold = 0;
          m_low = int'($urandom_range(6, 1));
        end
      end else if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) a_ready = 1'b0;
      end else if (!a_ready && m_low > 0) begin
        m_low--;
        if (m_low == 0) begin
          a_fdata = img(m_addr);
          a_ready = 1'b1;
        end
      end
    end
  end

  // SRAM scoreboard and write-strobe protocol monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (a_we === 1'b1) begin
        sram[a_ram_addr] = a_ram_data;
        a_we_cnt++;
        if (a_busy !== 1'b1) a_viol++;
      end
      if (a_sel !== (a_we ? 4'hF : 4'h0) || a_ce !== a_we) a_viol++;
      if (t_we !== 1'b0) t_we_cnt++;
      if (z_we !== 1'b0 || z_ce !== 1'b0) z_we_cnt++;
    end
  end

  initial begin
    int cyc;
    int w;
    key_hi = 8'($urandom);
    key_lo = 8'($urandom);
    rst = 1'b1;
    a_start = 1'b0; t_start = 1'b0; z_start = 1'b0;
    t_ready = 1'b0; t_fdata = 16'h0000;
    z_ready = 1'b0; z_fdata = 16'h0000;
    repeat (3) step();
    chk("rst_a_flags", {27'd0, a_busy, a_done, a_error, a_we, a_ce}, 32'd0);
    chk("rst_a_flash_addr", {10'd0, a_flash_addr}, 32'd0);
    chk("rst_a_ram_data", a_ram_data, 32'd0);
    chk("rst_a_words", {12'd0, a_words}, 32'd0);
    rst = 1'b0;
    repeat (20) step();

    // Zero-length image: DONE immediately, no bus activity.
    z_start = 1'b1;
    step();
    z_start = 1'b0;
    chk("zero_done_next", {30'd0, z_done, z_busy}, 32'd2);
    repeat (3) step();
    chk("zero_no_activity", {10'd0, z_flash_addr}, 32'd0);
    chk("zero_no_we", z_we_cnt, 32'd0);

    // Flash never ready: timeout to ERR, no writes.
    t_start = 1'b1;
    step();
    t_start = 1'b0;
    chk("tmo_busy_rise", {31'd0, t_busy}, 32'd1);
    cyc = 0;
    while (!t_error && cyc < 40) begin
      step();
      cyc++;
    end
    chk("tmo_error", {30'd0, t_error, t_busy}, 32'd2);
    chk("tmo_latency_ok", {31'd0, (cyc >= 16 && cyc <= 20)}, 32'd1);
    chk("tmo_no_we", t_we_cnt, 32'd0);

    // Run 1: normal copy with a start pulse while busy.
    sram.delete();
    a_we_cnt = 0;
    pulse_a_start();
    chk("run1_busy_rise", {30'd0, a_busy, a_done}, 32'd2);
    w = 0;
    while (a_words == 20'd0 && w < 1000) begin
      step();
      w++;
    end
    pulse_a_start();
    chk("busy_start_ignored", {30'd0, a_busy, (a_words != 20'd0)}, 32'd3);
    wait_a_done("run1");
    check_image("run1");

    // Run 2: restart from DONE with ready lingering across address changes.
    stale_mode = 1'b1;
    sram.delete();
    a_we_cnt = 0;
    pulse_a_start();
    chk("restart_clears", {11'd0, a_busy, a_done, a_words}, {11'd0, 1'b1, 1'b0, 20'd0});
    wait_a_done("run2");
    check_image("stale");
    stale_mode = 1'b0;

    // Run 3: reset during the write of word 1, then a full clean copy.
    pulse_a_start();
    w = 0;
    while (!(a_we && a_ram_addr == A_RB + 20'd1) && w < 1000) begin
      step();
      w++;
    end
    chk("reached_word1_write", {31'd0, a_we}, 32'd1);
    rst = 1'b1;
    step();
    chk("midrst_flags", {27'd0, a_busy, a_done, a_error, a_we, a_ce}, 32'd0);
    chk("midrst_addrs", {a_ram_addr, a_sel, 8'd0}, 32'd0);
    chk("midrst_flash_addr", {10'd0, a_flash_addr}, 32'd0);
    chk("midrst_data_words", {a_ram_data[11:0], a_words}, 32'd0);
    rst = 1'b0;
    repeat (20) step();
    sram.delete();
    a_we_cnt = 0;
    pulse_a_start();
    wait_a_done("run4");
    check_image("after_rst");
    chk("we_protocol", a_viol, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
